// File: rtl/mac_sequencer_if.sv
// Handshake/address bundle between the MAC sequencer and its environment.
// The master drives the run controls; the slave (sequencer) drives addresses and accumulator commands.
interface mac_sequencer_if #(
    parameter int unsigned ADDR_W = 3
) ();
    logic              enable;
    logic              strobe_in;
    logic              clear_overrun;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] coeff_addr;
    logic [ADDR_W-1:0] data_addr;
    logic              addr_valid;
    logic              acc_clear;
    logic              acc_enable;
    logic              strobe_out;
    logic              busy;
    logic              overrun;

    modport master (
        output enable, strobe_in, clear_overrun,
        input  wr_addr, coeff_addr, data_addr, addr_valid,
               acc_clear, acc_enable, strobe_out, busy, overrun
    );

    modport slave (
        input  enable, strobe_in, clear_overrun,
        output wr_addr, coeff_addr, data_addr, addr_valid,
               acc_clear, acc_enable, strobe_out, busy, overrun
    );
endinterface

// File: rtl/mac_sequencer.sv
// FIR-style MAC sequencer: issues NTAPS coefficient/sample address pairs per input sample
// and times accumulator clear/add commands through a MULT_LAT-deep token pipeline.
module mac_sequencer #(
    parameter int unsigned NTAPS    = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned MULT_LAT = 2
) (
    input  logic           clock,
    input  logic           reset,
    mac_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NTAPS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] coeff_q;
    logic [ADDR_W-1:0] data_q;
    logic              addr_valid_q;
    logic              strobe_q;
    logic              busy_q;
    logic              overrun_q;
    // Stage 0 is aligned with the address; stage MULT_LAT drives the accumulator.
    logic [MULT_LAT:0] clr_q;
    logic [MULT_LAT:0] en_q;
    logic              pending_c;

    // Any token still short of the accumulator stage
    always_comb begin
        pending_c = 1'b0;
        for (int i = 0; i < int'(MULT_LAT); i++) begin
            pending_c = pending_c | clr_q[i] | en_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_addr_q    <= '0;
            coeff_q      <= '0;
            data_q       <= '0;
            addr_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            clr_q        <= '0;
            en_q         <= '0;
        end else begin
            if (bus.enable && bus.strobe_in && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (bus.clear_overrun) begin
                overrun_q <= 1'b0;
            end

            for (int i = 1; i <= int'(MULT_LAT); i++) begin
                clr_q[i] <= clr_q[i-1];
                en_q[i]  <= en_q[i-1];
            end
            clr_q[0]     <= 1'b0;
            en_q[0]      <= 1'b0;
            addr_valid_q <= 1'b0;
            coeff_q      <= '0;
            data_q       <= '0;
            strobe_q     <= 1'b0;

            if (!bus.enable && (state_q != IDLE)) begin
                state_q <= IDLE;
                clr_q   <= '0;
                en_q    <= '0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.enable && bus.strobe_in) begin
                            state_q      <= ISSUE;
                            wr_addr_q    <= wr_addr_q + ADDR_W'(1);
                            data_q       <= wr_addr_q;
                            addr_valid_q <= 1'b1;
                            clr_q[0]     <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        if (coeff_q == LAST_K) begin
                            state_q  <= (MULT_LAT == 0) ? DONE : DRAIN;
                            strobe_q <= (MULT_LAT == 0);
                        end else begin
                            addr_valid_q <= 1'b1;
                            coeff_q      <= coeff_q + ADDR_W'(1);
                            data_q       <= data_q - ADDR_W'(1);
                            en_q[0]      <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!pending_c) begin
                            state_q  <= DONE;
                            strobe_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_addr    = wr_addr_q;
    assign bus.coeff_addr = coeff_q;
    assign bus.data_addr  = data_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.acc_clear  = clr_q[MULT_LAT];
    assign bus.acc_enable = en_q[MULT_LAT];
    assign bus.strobe_out = strobe_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: NTAPS=4/MULT_LAT=2 and NTAPS=1/MULT_LAT=0 instances,
// with a reference accumulator fed addend k+1.
module tb_mac_sequencer;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   acc_ref  = 0;
    int   tok_ref  = 0;

    always #5 clock = ~clock;

    mac_sequencer_if #(.ADDR_W(3)) b4 ();
    mac_sequencer_if #(.ADDR_W(3)) b1 ();

    mac_sequencer #(.NTAPS(4), .ADDR_W(3), .MULT_LAT(2)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4)
    );

    mac_sequencer #(.NTAPS(1), .ADDR_W(3), .MULT_LAT(0)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    // Reference accumulator: load 1 on clear, add k+1 on each enable
    always @(posedge clock) begin
        if (reset) begin
            acc_ref <= 0;
            tok_ref <= 0;
        end else if (b4.acc_clear) begin
            acc_ref <= 1;
            tok_ref <= 1;
        end else if (b4.acc_enable) begin
            acc_ref <= acc_ref + tok_ref + 1;
            tok_ref <= tok_ref + 1;
        end
    end

    function automatic logic [14:0] pack4();
        return {b4.wr_addr, b4.coeff_addr, b4.data_addr, b4.addr_valid, b4.acc_clear,
                b4.acc_enable, b4.strobe_out, b4.busy, b4.overrun};
    endfunction

    function automatic logic [14:0] pack1();
        return {b1.wr_addr, b1.coeff_addr, b1.data_addr, b1.addr_valid, b1.acc_clear,
                b1.acc_enable, b1.strobe_out, b1.busy, b1.overrun};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fields: wr, coeff, data, addr_valid, acc_clear, acc_enable, strobe_out, busy, overrun
    task automatic expect_out(input string tag, input logic [14:0] obs,
                              input int wr, input int co, input int da, input bit av,
                              input bit cl, input bit en, input bit so, input bit bz, input bit ov);
        logic [14:0] exp;
        exp = {3'(wr), 3'(co), 3'(da), av, cl, en, so, bz, ov};
        chk(tag, 32'(obs), 32'(exp));
        chk({tag, "_excl"}, 32'(obs[4] & obs[3]), 32'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        b4.enable = 1'b0; b4.strobe_in = 1'b0; b4.clear_overrun = 1'b0;
        b1.enable = 1'b0; b1.strobe_in = 1'b0; b1.clear_overrun = 1'b0;
        step();
        step();
        expect_out("rst4", pack4(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("rst1", pack1(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        b4.enable = 1'b1;
        step();

        // Run 1: base wr_addr 0, overrun in cycle 4, cleared in cycle 7
        b4.strobe_in = 1'b1;
        expect_out("r1c0", pack4(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); b4.strobe_in = 1'b0;
        expect_out("r1c1", pack4(), 1, 0, 0, 1, 0, 0, 0, 1, 0);
        step();
        expect_out("r1c2", pack4(), 1, 1, 7, 1, 0, 0, 0, 1, 0);
        step();
        expect_out("r1c3", pack4(), 1, 2, 6, 1, 1, 0, 0, 1, 0);
        step();
        expect_out("r1c4", pack4(), 1, 3, 5, 1, 0, 1, 0, 1, 0);
        b4.strobe_in = 1'b1;
        step(); b4.strobe_in = 1'b0;
        expect_out("r1c5", pack4(), 1, 0, 0, 0, 0, 1, 0, 1, 1);
        step();
        expect_out("r1c6", pack4(), 1, 0, 0, 0, 0, 1, 0, 1, 1);
        step();
        expect_out("r1c7", pack4(), 1, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("r1_sum", 32'(acc_ref), 32'd10);
        b4.clear_overrun = 1'b1;
        step(); b4.clear_overrun = 1'b0;
        expect_out("r1c8", pack4(), 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Run 2: base wr_addr 1, enable dropped in cycle 5
        b4.strobe_in = 1'b1;
        step(); b4.strobe_in = 1'b0;
        expect_out("r2c1", pack4(), 2, 0, 1, 1, 0, 0, 0, 1, 0);
        step();
        expect_out("r2c2", pack4(), 2, 1, 0, 1, 0, 0, 0, 1, 0);
        step();
        expect_out("r2c3", pack4(), 2, 2, 7, 1, 1, 0, 0, 1, 0);
        step();
        expect_out("r2c4", pack4(), 2, 3, 6, 1, 0, 1, 0, 1, 0);
        step();
        expect_out("r2c5", pack4(), 2, 0, 0, 0, 0, 1, 0, 1, 0);
        b4.enable = 1'b0;
        step();
        expect_out("r2c6", pack4(), 2, 0, 0, 0, 0, 0, 0, 0, 0);
        b4.strobe_in = 1'b1;
        step(); b4.strobe_in = 1'b0;
        expect_out("r2c7", pack4(), 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("r2c8", pack4(), 2, 0, 0, 0, 0, 0, 0, 0, 0);
        b4.enable = 1'b1;

        // Run 3: reset in cycle 3 with a coincident strobe, then a fresh run
        b4.strobe_in = 1'b1;
        step(); b4.strobe_in = 1'b0;
        expect_out("r3c1", pack4(), 3, 0, 2, 1, 0, 0, 0, 1, 0);
        step();
        step();
        expect_out("r3c3", pack4(), 3, 2, 0, 1, 1, 0, 0, 1, 0);
        reset = 1'b1;
        b4.strobe_in = 1'b1;
        step(); reset = 1'b0;
        expect_out("r3c4", pack4(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); b4.strobe_in = 1'b0;
        expect_out("r3c5", pack4(), 1, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step();
        expect_out("r3c11", pack4(), 1, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("r3_sum", 32'(acc_ref), 32'd10);
        step();
        expect_out("r3c12", pack4(), 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // NTAPS=1, MULT_LAT=0 instance
        b1.enable = 1'b1;
        step();
        b1.strobe_in = 1'b1;
        expect_out("n1c0", pack1(), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); b1.strobe_in = 1'b0;
        expect_out("n1c1", pack1(), 1, 0, 0, 1, 1, 0, 0, 1, 0);
        step();
        expect_out("n1c2", pack1(), 1, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        expect_out("n1c3", pack1(), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        b1.strobe_in = 1'b1;
        step(); b1.strobe_in = 1'b0;
        expect_out("n1c4", pack1(), 2, 0, 1, 1, 1, 0, 0, 1, 0);
        step();
        expect_out("n1c5", pack1(), 2, 0, 0, 0, 0, 0, 1, 1, 0);
        step();
        expect_out("n1c6", pack1(), 2, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 8, products accumulated per output sample (legal range 1..2^ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 3, width of coefficient and sample-buffer addresses.
REQ-003 SHALL have parameter MULT_LAT, default 2, cycles from address issue to addend valid at the accumulator (legal range 0..7).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  master run enable.
REQ-007 SHALL have port strobe_in  input  1  one-cycle pulse: new input sample written at wr_addr.
REQ-008 SHALL have port clear_overrun  input  1  clears the sticky overrun flag.
REQ-009 SHALL have port wr_addr  output  ADDR_W  circular sample-buffer write pointer.
REQ-010 SHALL have port coeff_addr  output  ADDR_W  coefficient memory address, tap index k.
REQ-011 SHALL have port data_addr  output  ADDR_W  sample address, (latched wr_addr - k) mod 2^ADDR_W.
REQ-012 SHALL have port addr_valid  output  1  coeff_addr/data_addr valid this cycle.
REQ-013 SHALL have port acc_clear  output  1  accumulator load-addend command.
REQ-014 SHALL have port acc_enable  output  1  accumulator add-addend command.
REQ-015 SHALL have port strobe_out  output  1  one-cycle pulse: accumulator sum valid this cycle.
REQ-016 SHALL have port busy  output  1  computation in progress.
REQ-017 SHALL have port overrun  output  1  sticky: strobe_in arrived while busy.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE; encoding free.
REQ-019 IDLE: strobe_in with enable high SHALL latch wr_addr, increment wr_addr mod 2^ADDR_W, and go to ISSUE next cycle (accept cycle = t0).
REQ-020 ISSUE SHALL last exactly NTAPS cycles, t0+1..t0+NTAPS, with addr_valid high and coeff_addr = k in cycle t0+1+k, k = 0..NTAPS-1.
REQ-021 Each issued address SHALL launch a token through a MULT_LAT-deep shift pipeline; token for k=0 asserts acc_clear, tokens for k>=1 assert acc_enable, in cycle t0+1+MULT_LAT+k.
REQ-022 acc_clear and acc_enable SHALL never be high in the same cycle.
REQ-023 After ISSUE, the block SHALL sit in DRAIN until the last token has been emitted; with MULT_LAT=0, DRAIN lasts zero cycles.
REQ-024 DONE SHALL assert strobe_out for exactly one cycle, t0+1+MULT_LAT+NTAPS, then return to IDLE.
REQ-025 busy SHALL be high from t0+1 through the strobe_out cycle inclusive; otherwise low.
REQ-026 strobe_in while busy SHALL be ignored (no wr_addr change) and SHALL set overrun; a new strobe_in is accepted in the cycle after strobe_out.
REQ-027 clear_overrun SHALL clear overrun next cycle; if overrun-set and clear_overrun coincide, set wins.
REQ-028 enable low in any non-IDLE state SHALL abort: IDLE next cycle, pipeline tokens flushed, no strobe_out, wr_addr retained.
REQ-029 strobe_in with enable low SHALL be ignored and SHALL NOT set overrun.
REQ-030 NTAPS=1 SHALL yield a single acc_clear and no acc_enable.
REQ-031 data_addr and coeff_addr SHALL wrap mod 2^ADDR_W; outside addr_valid they SHALL hold 0.

Reset
REQ-032 reset SHALL force IDLE, flush pipeline tokens, and set wr_addr, coeff_addr, data_addr to 0 and addr_valid, acc_clear, acc_enable, strobe_out, busy, overrun to 0.
REQ-033 reset mid-computation SHALL take priority over all inputs; no strobe_out follows.

Verification
REQ-034 NTAPS=4, MULT_LAT=2, strobe_in cycle 0 -> coeff_addr 0,1,2,3 cycles 1-4; acc_clear cycle 3; acc_enable cycles 4-6; strobe_out cycle 7; with reference acc fed addend k+1, sum=10 at cycle 7.
REQ-035 wr_addr=1, ADDR_W=3, NTAPS=4 -> data_addr 1,0,7,6; wr_addr becomes 2.
REQ-036 strobe_in in cycle 4 of REQ-034 run -> overrun=1, run unchanged; clear_overrun -> overrun=0 next cycle.
REQ-037 enable dropped cycle 5 of REQ-034 run -> IDLE cycle 6, no acc_enable after cycle 5, no strobe_out.
REQ-038 NTAPS=1, MULT_LAT=0, strobe_in cycle 0 -> acc_clear cycle 1, strobe_out cycle 2, new strobe_in accepted cycle 3.
REQ-039 reset asserted cycle 3 of REQ-034 run -> all outputs 0 cycle 4; a fresh strobe_in starts from wr_addr=0.
